// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma sample sequencer: state encoding,
// modulator input constants and the default sample width.
package dsm_pkg;

  localparam int DSM_DW = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } dsm_state_t;

  // Zero input and +1 V full-scale in the modulator vin format.
  localparam logic [DSM_DW-1:0] VIN_ZERO = 20'h0_0000;
  localparam logic [DSM_DW-1:0] VIN_FS   = 20'h0_8000;

endpackage

// File: rtl/dsm_sample_fifo.sv
// Two-entry sample FIFO with a combinational head; push and pop may coincide,
// including when full, in which case occupancy is unchanged.
module dsm_sample_fifo
  import dsm_pkg::*;
#(
  parameter int DW = DSM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == 2'd2);
  assign empty   = (count_reg == 2'd0);
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= din;
        wr_ptr_reg      <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dsm_sample_sequencer.sv
// Feeds buffered samples to the delta-sigma modulator, holding each for OSR
// cycles, and owns the modulator reset including a zero-input flush on stop.
module dsm_sample_sequencer
  import dsm_pkg::*;
#(
  parameter int DW           = DSM_DW,
  parameter int OSR_W        = 8,
  parameter int FLUSH_CYCLES = 64,
  parameter int UCNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [OSR_W-1:0]  osr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic [DW-1:0]     vin,
  output logic              dsm_rst,
  output logic              sample_tick,
  output logic [UCNT_W-1:0] underrun_cnt,
  output logic              busy
);

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [DW-1:0] ZERO = DW'(VIN_ZERO);

  dsm_state_t       state_reg, state_next;
  logic [OSR_W-1:0] osr_reg, osr_next;
  logic [OSR_W-1:0] phase_reg, phase_next;
  logic [FC_W-1:0]  flush_reg, flush_next;

  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_head;
  logic          push;
  logic          pop;
  logic          load_tick;
  logic          underrun;
  logic          period_end;

  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign busy       = (state_reg != ST_IDLE);
  assign period_end = (phase_reg == osr_reg - OSR_W'(1));

  dsm_sample_fifo #(
    .DW(DW)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .din  (s_data),
    .pop  (pop),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    osr_next   = osr_reg;
    phase_next = phase_reg;
    flush_next = flush_reg;
    pop        = 1'b0;
    load_tick  = 1'b0;
    underrun   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_RUN;
          osr_next   = (osr == '0) ? OSR_W'(1) : osr;
          phase_next = '0;
        end
      end
      ST_RUN: begin
        // Stop is only honoured on the last cycle of a sample period.
        if (period_end && !enable) begin
          state_next = ST_FLUSH;
          flush_next = '0;
          phase_next = '0;
        end else begin
          if (phase_reg == '0) begin
            load_tick = 1'b1;
            pop       = !fifo_empty;
            underrun  = fifo_empty;
          end
          phase_next = period_end ? '0 : phase_reg + OSR_W'(1);
        end
      end
      ST_FLUSH: begin
        if (flush_reg == FC_W'(FLUSH_CYCLES - 1)) begin
          state_next = ST_IDLE;
        end else begin
          flush_next = flush_reg + FC_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      osr_reg      <= OSR_W'(1);
      phase_reg    <= '0;
      flush_reg    <= '0;
      vin          <= ZERO;
      dsm_rst      <= 1'b1;
      sample_tick  <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_reg   <= state_next;
      osr_reg     <= osr_next;
      phase_reg   <= phase_next;
      flush_reg   <= flush_next;
      sample_tick <= load_tick;
      dsm_rst     <= (state_next == ST_IDLE);
      if (load_tick) begin
        vin <= fifo_empty ? ZERO : fifo_head;
      end else if (state_next != ST_RUN) begin
        vin <= ZERO;
      end
      if (underrun && (underrun_cnt != '1)) begin
        underrun_cnt <= underrun_cnt + UCNT_W'(1);
      end
    end
  end

endmodule
